// File: rtl/exe_iter_stage.sv
// exe_iter_stage
// Execute stage of the ARM32 pipeline: single-cycle ALU plus an iterative
// radix-2^RADIX_BITS multiplier for MUL/MLA. ID hands over operations through
// a valid/ready handshake; results leave through the registered EXE/MEM
// interface. NZCV flags live inside this stage.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           kills the in-flight multiply and any op offered this cycle
//   in_valid        operation offered          in_ready  stage can accept (IDLE)
//   exe_cmd, S      opcode, update-flags       WB_EN, dest  carried to output
//   val1, val2, acc operands (acc = Ra for MLA)
//   out_valid       registered result valid    alu_res   registered result
//   dest_out        registered destination     WB_EN_out write-back, 0 on bubbles
//   status          {N,Z,C,V}
module exe_iter_stage #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      exe_cmd,
  input  logic            S,
  input  logic            WB_EN,
  input  logic [3:0]      dest,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] acc,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_res,
  output logic [3:0]      dest_out,
  output logic            WB_EN_out,
  output logic [3:0]      status
);

  localparam int ITER = XLEN / RADIX_BITS;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_MLA = 4'b1101;

  // control / multiplier state
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;    // val1 pre-shifted by k*R
  logic [XLEN-1:0] mplier_q, mplier_d;  // val2 consumed from the bottom
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] psum_q, psum_d;
  logic            mla_q, mla_d;
  logic            s_q, s_d;
  logic            wb_q, wb_d;
  logic [3:0]      dst_q, dst_d;

  // output registers
  logic            ov_q, ov_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [3:0]      dout_q, dout_d;
  logic            wbo_q, wbo_d;
  logic [3:0]      st_q, st_d;

  logic            accept, is_mul, last;
  logic            arith, cin, c_out, v_out;
  logic [XLEN-1:0] b_eff, alu_r, pp, psum_nxt, mul_fin;
  logic [XLEN:0]   alu_sum;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mul   = (exe_cmd == OP_MUL) || (exe_cmd == OP_MLA);
  assign last     = (cnt_q == CW'(ITER - 1));

  // Subtraction is a + ~b + carry-in, so C comes out as NOT borrow directly.
  always_comb begin
    b_eff = val2;
    cin   = 1'b0;
    arith = 1'b0;
    case (exe_cmd)
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; cin = st_q[1]; end
      OP_SUB: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
      OP_SBC: begin arith = 1'b1; b_eff = ~val2; cin = st_q[1]; end
      default: ;
    endcase
    alu_sum = {1'b0, val1} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};
    c_out   = alu_sum[XLEN];
    v_out   = (val1[XLEN-1] == b_eff[XLEN-1]) && (alu_sum[XLEN-1] != val1[XLEN-1]);
    case (exe_cmd)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_r = alu_sum[XLEN-1:0];
      OP_AND:  alu_r = val1 & val2;
      OP_ORR:  alu_r = val1 | val2;
      OP_EOR:  alu_r = val1 ^ val2;
      OP_MVN:  alu_r = ~val2;
      default: alu_r = val2;
    endcase
  end

  // One radix digit per cycle; the multiplicand is kept pre-shifted so the
  // partial product needs no variable shifter. Truncation to XLEN is implicit.
  assign pp       = mcand_q * XLEN'(mplier_q[RADIX_BITS-1:0]);
  assign psum_nxt = psum_q + pp;
  assign mul_fin  = psum_nxt + (mla_q ? acc_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    psum_d   = psum_q;
    mla_d    = mla_q;
    s_d      = s_q;
    wb_d     = wb_q;
    dst_d    = dst_q;
    ov_d     = 1'b0;
    wbo_d    = 1'b0;
    res_d    = res_q;
    dout_d   = dout_q;
    st_d     = st_q;
    if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        state_d  = S_BUSY;
        cnt_d    = '0;
        psum_d   = '0;
        mcand_d  = val1;
        mplier_d = val2;
        acc_d    = acc;
        mla_d    = (exe_cmd == OP_MLA);
        s_d      = S;
        wb_d     = WB_EN;
        dst_d    = dest;
      end else if (accept) begin
        ov_d   = 1'b1;
        wbo_d  = WB_EN;
        res_d  = alu_r;
        dout_d = dest;
        if (S)
          st_d = {alu_r[XLEN-1], (alu_r == '0),
                  arith ? c_out : st_q[1], arith ? v_out : st_q[0]};
      end
    end else if (flush) begin
      // flush wins even over the completing cycle
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      psum_d   = psum_nxt;
      cnt_d    = cnt_q + CW'(1);
      mcand_d  = mcand_q << RADIX_BITS;
      mplier_d = mplier_q >> RADIX_BITS;
      if (last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ov_d    = 1'b1;
        wbo_d   = wb_q;
        res_d   = mul_fin;
        dout_d  = dst_q;
        if (s_q)
          st_d = {mul_fin[XLEN-1], (mul_fin == '0), st_q[1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      psum_q   <= '0;
      mla_q    <= 1'b0;
      s_q      <= 1'b0;
      wb_q     <= 1'b0;
      dst_q    <= '0;
      ov_q     <= 1'b0;
      res_q    <= '0;
      dout_q   <= '0;
      wbo_q    <= 1'b0;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      psum_q   <= psum_d;
      mla_q    <= mla_d;
      s_q      <= s_d;
      wb_q     <= wb_d;
      dst_q    <= dst_d;
      ov_q     <= ov_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      wbo_q    <= wbo_d;
      st_q     <= st_d;
    end
  end

  assign out_valid = ov_q;
  assign alu_res   = res_q;
  assign dest_out  = dout_q;
  assign WB_EN_out = wbo_q;
  assign status    = st_q;

endmodule

// File: tb/tb_exe_iter_stage.sv
// Bench for exe_iter_stage. Four instances share the stimulus with
// RADIX_BITS = 2, 1, 4, 8; directed checks use instance 0 (RADIX_BITS = 2)
// except for the multiply latency check, which looks at all four.
module tb_exe_iter_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, S, WB_EN;
  logic [3:0]  exe_cmd, dest;
  logic [31:0] val1, val2, acc;

  logic [3:0]       rdy, ov, wbo;
  logic [3:0][31:0] res;
  logic [3:0][3:0]  dst, st;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RB = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    exe_iter_stage #(.XLEN(32), .RADIX_BITS(RB)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[g]),
      .exe_cmd(exe_cmd), .S(S), .WB_EN(WB_EN), .dest(dest),
      .val1(val1), .val2(val2), .acc(acc),
      .out_valid(ov[g]), .alu_res(res[g]), .dest_out(dst[g]),
      .WB_EN_out(wbo[g]), .status(st[g])
    );
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] a, b, ac,
                       input logic s, wb, input logic [3:0] d, input logic v, f);
    exe_cmd = c; val1 = a; val2 = b; acc = ac; S = s; WB_EN = wb;
    dest = d; in_valid = v; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: arithmetic on 64-bit integers, C/V from numeric range rules.
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, b,
                                  input logic cin, output logic [31:0] r,
                                  output logic ar, cf, vf);
    longint unsigned ua = a, ub = b, ur;
    longint sa = $signed(a), sb = $signed(b), sr;
    ar = 1'b1; cf = 1'b0; sr = 0; ur = 0;
    case (c)
      4'd2: begin ur = ua + ub; sr = sa + sb; cf = ur > 64'hFFFF_FFFF; end
      4'd3: begin ur = ua + ub + cin; sr = sa + sb + longint'(cin);
                  cf = ur > 64'hFFFF_FFFF; end
      4'd4: begin ur = ua - ub; sr = sa - sb; cf = ua >= ub; end
      4'd5: begin ur = ua - ub - !cin; sr = sa - sb - longint'(!cin);
                  cf = ua >= ub + !cin; end
      default: ar = 1'b0;
    endcase
    case (c)
      4'd2, 4'd3, 4'd4, 4'd5: r = ur[31:0];
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd9: r = ~b;
      default: r = b;
    endcase
    vf = ar && (sr != longint'($signed(r)));
  endfunction

  task automatic test_reset();
    drive(4'd2, 32'h1234, 32'h5678, 0, 1, 1, 4'd6, 1, 0);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (res[0] !== 32'd0) begin n_bad++; $display("FAIL rst_res got %h exp 0", res[0]); end
    n_cmp++; if (dst[0] !== 4'd0) begin n_bad++; $display("FAIL rst_dest got %h exp 0", dst[0]); end
    n_cmp++; if (ov[0] !== 1'b0 || wbo[0] !== 1'b0) begin n_bad++; $display("FAIL rst_valid got ov=%b wb=%b exp 0 0", ov[0], wbo[0]); end
    n_cmp++; if (st[0] !== 4'b0000) begin n_bad++; $display("FAIL rst_status got %b exp 0000", st[0]); end
    n_cmp++; if (rdy !== 4'hF) begin n_bad++; $display("FAIL rst_ready got %b exp 1111", rdy); end
  endtask

  task automatic test_add();
    drive(4'd2, 32'd5, 32'd7, 0, 1, 1, 4'd3, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (res[0] !== 32'd12) begin n_bad++; $display("FAIL add_res got %h exp %h", res[0], 32'd12); end
    n_cmp++; if (dst[0] !== 4'd3 || ov[0] !== 1'b1 || wbo[0] !== 1'b1) begin n_bad++; $display("FAIL add_ctl got d=%h ov=%b wb=%b exp 3 1 1", dst[0], ov[0], wbo[0]); end
    n_cmp++; if (st[0] !== 4'b0000) begin n_bad++; $display("FAIL add_status got %b exp 0000", st[0]); end
    tick();
    n_cmp++; if (ov[0] !== 1'b0 || wbo[0] !== 1'b0 || res[0] !== 32'd12) begin n_bad++; $display("FAIL bubble got ov=%b wb=%b res=%h exp 0 0 0000000c", ov[0], wbo[0], res[0]); end
  endtask

  task automatic test_sub_adc();
    drive(4'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, 4'd1, 1, 0);
    tick();
    n_cmp++; if (res[0] !== 32'h8000_0000) begin n_bad++; $display("FAIL sub_res got %h exp 80000000", res[0]); end
    n_cmp++; if (st[0] !== 4'b1001) begin n_bad++; $display("FAIL sub_status got %b exp 1001", st[0]); end
    drive(4'd3, 32'd1, 32'd1, 0, 1, 1, 4'd2, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (res[0] !== 32'd2) begin n_bad++; $display("FAIL adc_res got %h exp 2", res[0]); end
    n_cmp++; if (st[0] !== 4'b0000) begin n_bad++; $display("FAIL adc_status got %b exp 0000", st[0]); end
    tick();
  endtask

  task automatic test_back_to_back_mul();
    int bad_busy = 0;
    drive(4'd12, 32'd7, 32'd6, 0, 0, 1, 4'd4, 1, 0);
    tick();
    // ADD held on the bus while the multiplier is busy
    drive(4'd2, 32'd10, 32'd20, 0, 0, 1, 4'd5, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      if (rdy[0] !== 1'b0 || ov[0] !== 1'b0) bad_busy++;
      tick();
    end
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL mul_busy got %0d bad cycles exp 0", bad_busy); end
    n_cmp++; if (ov[0] !== 1'b1 || res[0] !== 32'd42 || dst[0] !== 4'd4) begin n_bad++; $display("FAIL mul_res got ov=%b res=%h d=%h exp 1 0000002a 4", ov[0], res[0], dst[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL mul_ready got %b exp 1", rdy[0]); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ov[0] !== 1'b1 || res[0] !== 32'd30 || dst[0] !== 4'd5) begin n_bad++; $display("FAIL held_add got ov=%b res=%h d=%h exp 1 0000001e 5", ov[0], res[0], dst[0]); end
    tick();
    n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL mul_single_pulse got %b exp 0", ov[0]); end
  endtask

  task automatic test_mla();
    bit seen = 0;
    drive(4'd2, 32'hFFFF_FFFF, 32'd1, 0, 1, 1, 4'd0, 1, 0);
    tick();
    n_cmp++; if (st[0] !== 4'b0110) begin n_bad++; $display("FAIL carry_preset got %b exp 0110", st[0]); end
    drive(4'd13, 32'hFFFF_FFFF, 32'd2, 32'd3, 1, 1, 4'd8, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ov[0] === 1'b1) seen = 1; else tick();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL mla_timeout got no out_valid exp out_valid"); end
    n_cmp++; if (res[0] !== 32'd1) begin n_bad++; $display("FAIL mla_res got %h exp 00000001", res[0]); end
    n_cmp++; if (st[0] !== 4'b0010) begin n_bad++; $display("FAIL mla_status got %b exp 0010", st[0]); end
    tick();
  endtask

  task automatic test_flush();
    logic [3:0]  st0;
    logic [31:0] r0;
    logic [3:0]  d0;
    int stray = 0;
    st0 = st[0]; r0 = res[0]; d0 = dst[0];
    drive(4'd12, 32'd0, 32'd5, 0, 1, 1, 4'd9, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();   // now in the 5th BUSY cycle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin n_bad++; $display("FAIL flush_busy got ov=%b rdy=%b exp 0 1", ov[0], rdy[0]); end
    n_cmp++; if (st[0] !== st0) begin n_bad++; $display("FAIL flush_status got %b exp %b", st[0], st0); end
    for (int i = 0; i < 20; i++) begin
      if (ov[0] !== 1'b0) stray++;
      tick();
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL flush_stray got %0d valid cycles exp 0", stray); end
    drive(4'd2, 32'd1, 32'd1, 0, 1, 1, 4'd7, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ov[0] !== 1'b0 || res[0] !== r0 || dst[0] !== d0 || st[0] !== st0) begin n_bad++; $display("FAIL flush_drop got ov=%b res=%h d=%h st=%b exp 0 %h %h %b", ov[0], res[0], dst[0], st[0], r0, d0, st0); end
  endtask

  task automatic test_rst_mid();
    drive(4'd12, 32'd3, 32'd3, 0, 1, 1, 4'd2, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (res[0] !== 0 || dst[0] !== 0 || wbo[0] !== 0 || ov[0] !== 0 || st[0] !== 0) begin n_bad++; $display("FAIL rst_mid_outs got res=%h d=%h wb=%b ov=%b st=%b exp all 0", res[0], dst[0], wbo[0], ov[0], st[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b exp 1", rdy[0]); end
    drive(4'd2, 32'd2, 32'd3, 0, 1, 1, 4'd9, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ov[0] !== 1'b1 || res[0] !== 32'd5 || dst[0] !== 4'd9) begin n_bad++; $display("FAIL rst_mid_add got ov=%b res=%h d=%h exp 1 00000005 9", ov[0], res[0], dst[0]); end
  endtask

  task automatic test_latency();
    int lat_exp [4] = '{17, 33, 9, 5};
    int lat [4] = '{0, 0, 0, 0};
    logic [31:0] r_at [4];
    rst = 1'b1; tick(); rst = 1'b0;
    drive(4'd12, 32'd9, 32'd11, 0, 0, 1, 4'd1, 1, 0);
    tick();                              // accept cycle t ends here
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int g = 0; g < 4; g++)
        if (lat[g] == 0 && ov[g] === 1'b1) begin lat[g] = cyc; r_at[g] = res[g]; end
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      n_cmp++; if (lat[g] != lat_exp[g]) begin n_bad++; $display("FAIL latency_%0d got %0d exp %0d", g, lat[g], lat_exp[g]); end
      n_cmp++; if (lat[g] != 0 && r_at[g] !== 32'd99) begin n_bad++; $display("FAIL lat_res_%0d got %h exp 00000063", g, r_at[g]); end
    end
  endtask

  task automatic test_random(input int n);
    bit busy = 0;
    int left = 0;
    logic [31:0] pres, a, b, ac, r, e_res;
    logic [3:0]  pdst, c, d, e_dst, e_st;
    logic        pwb, ps, s, wb, v, f, ar, cf, vf, e_ov, e_wb;
    int bad0;
    rst = 1'b1; tick(); rst = 1'b0;
    e_res = 0; e_dst = 0; e_st = 0;
    for (int i = 0; i < n; i++) begin
      c  = ($urandom_range(0, 7) == 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF; 1: a = 32'h8000_0000; 2: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      ac = $urandom;
      s  = 1'($urandom); wb = 1'($urandom); d = 4'($urandom);
      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 19) == 0);
      drive(c, a, b, ac, s, wb, d, v, f);
      n_cmp++; if (rdy[0] !== !busy) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, rdy[0], !busy); end
      e_ov = 0; e_wb = 0;
      if (f) busy = 0;
      else if (busy) begin
        left--;
        if (left == 0) begin
          busy = 0; e_ov = 1; e_res = pres; e_dst = pdst; e_wb = pwb;
          if (ps) e_st[3:2] = {pres[31], pres == 0};
        end
      end else if (v) begin
        if (c == 4'd12 || c == 4'd13) begin
          busy = 1; left = 16; pres = a * b + ((c == 4'd13) ? ac : 32'd0);
          pdst = d; pwb = wb; ps = s;
        end else begin
          ref_alu(c, a, b, e_st[1], r, ar, cf, vf);
          e_ov = 1; e_res = r; e_dst = d; e_wb = wb;
          if (s) e_st = {r[31], r == 0, ar ? cf : e_st[1], ar ? vf : e_st[0]};
        end
      end
      tick();
      bad0 = n_bad;
      n_cmp++; if (ov[0] !== e_ov) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, ov[0], e_ov); end
      n_cmp++; if (wbo[0] !== e_wb) begin n_bad++; $display("FAIL rnd_wb cyc %0d got %b exp %b", i, wbo[0], e_wb); end
      n_cmp++; if (res[0] !== e_res) begin n_bad++; $display("FAIL rnd_res cyc %0d cmd %h got %h exp %h", i, c, res[0], e_res); end
      n_cmp++; if (dst[0] !== e_dst) begin n_bad++; $display("FAIL rnd_dest cyc %0d got %h exp %h", i, dst[0], e_dst); end
      n_cmp++; if (st[0] !== e_st) begin n_bad++; $display("FAIL rnd_status cyc %0d cmd %h got %b exp %b", i, c, st[0], e_st); end
      // resync to the DUT after a reported divergence so one bug doesn't flood the log
      if (n_bad != bad0) begin e_res = res[0]; e_dst = dst[0]; e_st = st[0]; end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_add();
    test_sub_adc();
    test_back_to_back_mul();
    test_mla();
    test_flush();
    test_rst_mid();
    test_latency();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_iter_stage.md
# exe_iter_stage

Parametrised execute stage for the ARM32 pipeline. It extends the single-cycle ALU stage with an iterative multiplier for MUL and MLA, a valid/ready handshake toward ID, and a flush input. It sits between the ID/EXE pipeline register and the MEM stage:

- Operands arrive already forwarded and shifted.
- Results, destination and write-back enable leave through a registered EXE/MEM interface.
- The NZCV flags are held internally.

## Interface

Parameters:
- XLEN, 32: datapath width. Must be a multiple of RADIX_BITS.
- RADIX_BITS, 2: multiplier bits consumed per cycle. Legal values are 1, 2, 4 and 8.
- ITER, XLEN/RADIX_BITS: derived, not overridable. Number of multiply iterations.

Ports:
- clk, input, 1: the only clock.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: kills the accepted-but-unfinished operation and any operation offered in the same cycle.
- in_valid, input, 1: an operation is offered.
- in_ready, output, 1: the stage accepts the operation this cycle. Equals (state == IDLE).
- exe_cmd, input, 4: operation code.
- S, input, 1: update flags with the result.
- WB_EN, input, 1: write-back enable, carried to the output.
- dest, input, 4: destination register, carried to the output.
- val1, input, XLEN: first operand (Rn, or the multiplicand).
- val2, input, XLEN: second operand (shifter output, or the multiplier).
- acc, input, XLEN: MLA accumulator (Ra).
- out_valid, output, 1: result valid this cycle.
- alu_res, output, XLEN: registered result.
- dest_out, output, 4: registered destination.
- WB_EN_out, output, 1: registered write-back enable. Forced to 0 whenever out_valid = 0.
- status, output, 4: NZCV flags, ordered {N,Z,C,V}, registered.

## Operation

Opcodes:
- 0001 MOV = val2
- 1001 MVN = ~val2
- 0010 ADD
- 0011 ADC: + C
- 0100 SUB
- 0101 SBC: val1 − val2 − !C
- 0110 AND
- 0111 ORR
- 1000 EOR
- 1100 MUL: low XLEN bits of val1·val2
- 1101 MLA: low XLEN bits of val1·val2 + acc
- Any other code behaves as MOV.

Acceptance:
- An operation is accepted when in_valid & in_ready & !flush.

States:
- IDLE:
  - An accepted ALU op registers its result next edge, and the stage stays in IDLE.
  - An accepted MUL/MLA latches its operands, clears the partial sum, sets the counter to 0 and moves to BUSY.
- BUSY:
  - Each cycle the partial sum adds val1 · val2[k·R +: R] << (k·R), with R = RADIX_BITS and k = counter. The sum is truncated to XLEN bits.
  - When counter = ITER−1, the final sum (plus the latched acc for MLA) is written to alu_res and the state returns to IDLE.
  - flush in BUSY returns the state to IDLE with no output and no flag change.

Flags, updated only when S = 1 on the cycle the result is registered:
- N = result[XLEN−1].
- Z = (result == 0).
- For ADD/ADC/SUB/SBC, C and V come from the XLEN+1-bit sum. SUB carry = NOT borrow, ARM convention.
- For logical ops, MOV, MVN, MUL and MLA, C and V are unchanged.
- ADC/SBC read C from the status register as it stands in the acceptance cycle.

Bubbles:
- A cycle with no accepted ALU op and no MUL completion gives out_valid = 0 and WB_EN_out = 0 next edge.
- alu_res and dest_out hold their values during bubbles.

## Timing

Reset (rst = 1 at an edge):
- state = IDLE, counter = 0.
- alu_res = 0, dest_out = 0, WB_EN_out = 0, out_valid = 0, status = 0000.
- in_ready = 1 from the following cycle.
- Reset during BUSY abandons the multiply.

Latency:
- ALU op accepted in cycle t gives out_valid in cycle t+1.
- MUL/MLA accepted in cycle t:
  - BUSY during cycles t+1 … t+ITER.
  - in_ready = 0 during those cycles.
  - out_valid in cycle t+ITER+1, high for exactly one cycle.
  - in_ready = 1 again in cycle t+ITER+1, so a new op can be accepted there with no gap.
- Back-to-back ALU ops: one per cycle, sustained.

Handshake and flush:
- An op offered while in_ready = 0 is not accepted. The upstream holds it (the stall signal is !in_ready).
- flush takes priority over acceptance and over BUSY completion, including completion in the final BUSY cycle.
- The flag value is visible on status in the same cycle as out_valid.

## Test plan

- Reset, then ADD with val1 = 5, val2 = 7, S = 1, dest = 3 → next cycle alu_res = 12, dest_out = 3, out_valid = 1, status = 0000.
- SUB with val1 = 0x7FFFFFFF, val2 = 0xFFFFFFFF, S = 1 → alu_res = 0x80000000, status = 1001 (N = 1, C = 0, V = 1). Follow with ADC 1 + 1 → alu_res = 2, because C = 0.
- MUL 7 × 6 with XLEN = 32, RADIX_BITS = 2, accepted in cycle t → in_ready low for cycles t+1 … t+16, alu_res = 42 with out_valid high only in cycle t+17. A second ADD held on in_valid is accepted in t+17 and produces its result in t+18.
- MLA with val1 = 0xFFFFFFFF, val2 = 2, acc = 3, S = 1, status preset C = 1 → alu_res = 0x00000001, N = 0, Z = 0, C and V unchanged.
- flush asserted in the 5th BUSY cycle of a MUL → no out_valid, status unchanged, in_ready = 1 next cycle. flush together with an in_valid ADD → the ADD is dropped.
- rst asserted mid-MUL → all outputs zero next cycle, then a clean ADD completes normally. Repeat the MUL with RADIX_BITS = 1, 4 and 8 to confirm latencies of 33, 9 and 5 cycles.
